// File: rtl/afg_pkg.sv
// Shared definitions for the function-generator shaping chain: waveform
// encodings, midscale/full-scale helpers and the quarter-wave sine entry generator.
package afg_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SAW  = 2'd2,
        WAVE_SQR  = 2'd3
    } wave_e;

    function automatic int mid_of(input int data_w);
        return 1 << (data_w - 1);
    endfunction

    function automatic int fs_of(input int data_w);
        return (1 << data_w) - 1;
    endfunction

    // round((MID-1) * sin(2*pi*(i+0.5)/2^addr_w)); only evaluated at elaboration.
    function automatic int sine_entry(input int i, input int addr_w, input int data_w);
        real x;
        real term;
        real sum;
        real scale;
        x     = 2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / real'(1 << addr_w);
        term  = x;
        sum   = x;
        for (int k = 1; k < 14; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        scale = real'((1 << (data_w - 1)) - 1);
        return $rtoi(scale * sum + 0.5);
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational quarter-wave sine table; entries are fixed at elaboration
// from ADDR_W/DATA_W so the table tracks the parameters automatically.
module sine_quarter_rom
    import afg_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10
) (
    input  logic [ADDR_W-3:0] idx,
    output logic [DATA_W-2:0] s
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    logic [DATA_W-2:0] rom_tbl [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam logic [DATA_W-2:0] ENTRY = (DATA_W-1)'(sine_entry(i, ADDR_W, DATA_W));
        assign rom_tbl[i] = ENTRY;
    end

    assign s = rom_tbl[idx];

endmodule

// File: rtl/waveform_shaper.sv
// Phase-to-amplitude stage: truncated phase -> sine/triangle/saw/square sample,
// scaled about midscale, offset-binary output with per-period sync.
module waveform_shaper
    import afg_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               EN,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic               phase_vld,
    input  logic [1:0]         wave_sel,
    input  logic [7:0]         amp,
    input  logic [ADDR_W-1:0]  duty,
    output logic [DATA_W-1:0]  wave_out,
    output logic               wave_vld,
    output logic               sync_out
);

    // Valid-only stream, no backpressure: a sample is accepted on every edge
    // where EN && phase_vld; each stage carries a valid bit, and Reset or EN=0
    // clears all of them so nothing in flight ever reaches the output.

    localparam logic [DATA_W-1:0] MID    = DATA_W'(mid_of(DATA_W));
    localparam logic [DATA_W-1:0] MID_M1 = DATA_W'(mid_of(DATA_W) - 1);
    localparam logic [DATA_W-1:0] FS     = DATA_W'(fs_of(DATA_W));

    logic              flush;
    logic [ADDR_W-1:0] p_in;
    assign flush = Reset || !EN;
    assign p_in  = phase_in[PHASE_W-1 -: ADDR_W];

    // Stage 1: capture phase and controls together.
    logic              v1, wrap1, last_msb;
    logic [ADDR_W-1:0] p1, duty1;
    logic [7:0]        amp1;
    wave_e             sel1;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            v1       <= 1'b0;
            last_msb <= 1'b0;
        end else if (!EN) begin
            v1 <= 1'b0;
        end else begin
            v1 <= phase_vld;
            if (phase_vld) begin
                p1       <= p_in;
                sel1     <= wave_e'(wave_sel);
                amp1     <= amp;
                duty1    <= duty;
                wrap1    <= last_msb & ~p_in[ADDR_W-1];
                last_msb <= p_in[ADDR_W-1];
            end
        end
    end

    // Stage 2: raw waveform value.
    logic [ADDR_W-2:0] tri_t;
    logic [ADDR_W-3:0] rom_idx;
    logic [DATA_W-2:0] rom_s;
    logic [DATA_W-1:0] sine_raw, raw_c;

    sine_quarter_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
        .idx (rom_idx),
        .s   (rom_s)
    );

    always_comb begin
        tri_t    = p1[ADDR_W-1] ? ~p1[ADDR_W-2:0] : p1[ADDR_W-2:0];
        rom_idx  = p1[ADDR_W-2] ? ~p1[ADDR_W-3:0] : p1[ADDR_W-3:0];
        sine_raw = p1[ADDR_W-1] ? (MID_M1 - DATA_W'(rom_s)) : (MID + DATA_W'(rom_s));
        raw_c    = '0;
        case (sel1)
            WAVE_SAW: raw_c = DATA_W'(p1) << (DATA_W - ADDR_W);
            WAVE_TRI: raw_c = DATA_W'(tri_t) << (DATA_W - ADDR_W + 1);
            WAVE_SQR: raw_c = (p1 < duty1) ? FS : '0;
            default:  raw_c = sine_raw;
        endcase
    end

    logic              v2, wrap2;
    logic [DATA_W-1:0] raw2;
    logic [7:0]        amp2;

    always_ff @(posedge Clock) begin
        if (flush) begin
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                raw2  <= raw_c;
                amp2  <= amp1;
                wrap2 <= wrap1;
            end
        end
    end

    // Stage 3: signed deviation from midscale times (amp+1).
    logic        [DATA_W:0]    d;
    logic        [9:0]         gain;
    logic signed [DATA_W+10:0] d_x, g_x, prod_c, prod3, shifted;
    logic        [DATA_W-1:0]  out_c;
    logic                      v3, wrap3;

    always_comb begin
        d       = {1'b0, raw2} - {1'b0, MID};
        gain    = {2'b00, amp2} + 10'd1;
        d_x     = (DATA_W+11)'($signed(d));
        g_x     = (DATA_W+11)'($signed(gain));
        prod_c  = d_x * g_x;
        shifted = prod3 >>> 8;
        out_c   = shifted[DATA_W-1:0] + MID;
    end

    always_ff @(posedge Clock) begin
        if (flush) begin
            v3 <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) begin
                prod3 <= prod_c;
                wrap3 <= wrap2;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (flush) begin
            wave_out <= MID;
            wave_vld <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            wave_vld <= v3;
            sync_out <= v3 & wrap3;
            if (v3) wave_out <= out_c;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{phase_in, shifted};

endmodule
